// File: rtl/spi_frame_loader.sv
// spi_frame_loader: decodes 32-bit SPI words into commands, streams pixel
// payloads into the back framebuffer through a small elastic FIFO, holds the
// panel brightness register and sequences double-buffer swaps on vsync.
// Optional feature: define SPI_LOADER_SWAP_EN to enable double buffering
// (SWAP opcode, vsync-aligned front_buf toggling, back-buffer MSB on fb_addr).
module spi_frame_loader #(
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [31:0]       word_in,
  input  logic              word_first,
  input  logic              word_done,
  output logic [ADDR_W:0]   fb_addr,
  output logic [23:0]       fb_data,
  output logic              fb_we,
  input  logic              fb_ready,
  input  logic              vsync,
  output logic              front_buf,
  output logic [7:0]        brightness,
  output logic              err_overflow,
  output logic              err_cmd
);

`ifdef SPI_LOADER_SWAP_EN
  localparam logic SWAP_EN = 1'b1;
`else
  localparam logic SWAP_EN = 1'b0;
`endif

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int ENT_W = ADDR_W + 1 + 24;
  localparam logic [PTR_W:0] DEPTH_V = (PTR_W + 1)'(FIFO_DEPTH);

  localparam logic [3:0] OP_WRITE  = 4'h1;
  localparam logic [3:0] OP_BRIGHT = 4'h2;
  localparam logic [3:0] OP_SWAP   = 4'h3;
  localparam logic [3:0] OP_CLR    = 4'h4;

  typedef enum logic {ST_IDLE = 1'b0, ST_PAYLOAD = 1'b1} state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] addr_r;
  logic [11:0]       count_r;
  logic              swap_pending_r;

  // The output register (fb_*) is the head slot of the FIFO; the memory holds
  // the remaining entries, so total occupancy = mem_cnt_r + fb_we.
  logic [ENT_W-1:0]  mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W:0]    mem_cnt_r;

  logic [3:0]        opcode_s;
  logic [11:0]       length_s;
  logic              hdr_s;
  logic              push_req_s;
  logic              pop_s;
  logic [PTR_W:0]    occ_s;
  logic              full_s;
  logic              push_ok_s;
  logic              head_free_s;
  logic              load_mem_s;
  logic              bypass_s;
  logic              mem_wr_s;
  logic              back_buf_s;
  logic [ENT_W-1:0]  push_entry_s;
  logic              swap_now_s;
  logic              unused_s;

  assign unused_s = ^word_in;

  // Decode the incoming word and derive FIFO push/pop/bypass and swap events.
  always_comb begin
    opcode_s     = word_in[31:28];
    length_s     = word_in[27:16];
    hdr_s        = word_done && ((state_r == ST_IDLE) || word_first);
    push_req_s   = word_done && (state_r == ST_PAYLOAD) && !word_first;
    pop_s        = fb_we && fb_ready;
    occ_s        = mem_cnt_r + (PTR_W + 1)'(fb_we);
    full_s       = (occ_s == DEPTH_V);
    push_ok_s    = push_req_s && (!full_s || pop_s);
    head_free_s  = !fb_we || pop_s;
    load_mem_s   = head_free_s && (mem_cnt_r != '0);
    bypass_s     = head_free_s && (mem_cnt_r == '0) && push_ok_s;
    mem_wr_s     = push_ok_s && !bypass_s;
    back_buf_s   = SWAP_EN ? ~front_buf : 1'b0;
    push_entry_s = {back_buf_s, addr_r, word_in[23:0]};
    swap_now_s   = SWAP_EN && vsync && swap_pending_r && (mem_cnt_r == '0) && !fb_we;
  end

  // Command FSM: header decode, payload address/count tracking, flags, swap.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r        <= ST_IDLE;
      addr_r         <= '0;
      count_r        <= 12'd0;
      swap_pending_r <= 1'b0;
      front_buf      <= 1'b0;
      brightness     <= 8'd0;
      err_overflow   <= 1'b0;
      err_cmd        <= 1'b0;
    end else begin
      if (swap_now_s) begin
        front_buf      <= ~front_buf;
        swap_pending_r <= 1'b0;
      end
      if (push_req_s) begin
        if (!push_ok_s) begin
          err_overflow <= 1'b1;
        end
        addr_r  <= addr_r + ADDR_W'(1);
        count_r <= count_r - 12'd1;
        if (count_r == 12'd1) begin
          state_r <= ST_IDLE;
        end
      end else if (hdr_s) begin
        state_r <= ST_IDLE;
        case (opcode_s)
          OP_WRITE: begin
            if (length_s != 12'd0) begin
              addr_r  <= word_in[ADDR_W-1:0];
              count_r <= length_s;
              state_r <= ST_PAYLOAD;
            end
          end
          OP_BRIGHT: brightness <= word_in[7:0];
          OP_SWAP: begin
            if (SWAP_EN) begin
              swap_pending_r <= 1'b1;
            end else begin
              err_cmd <= 1'b1;
            end
          end
          OP_CLR: begin
            err_overflow <= 1'b0;
            err_cmd      <= 1'b0;
          end
          default: err_cmd <= 1'b1;
        endcase
      end
    end
  end

  // FIFO memory write port; contents need no reset since occupancy gates use.
  always_ff @(posedge clk) begin
    if (mem_wr_s) begin
      mem_r[wr_ptr_r] <= push_entry_s;
    end
  end

  // FIFO pointers and the registered framebuffer write head (with bypass).
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      mem_cnt_r <= '0;
      fb_we     <= 1'b0;
      fb_addr   <= '0;
      fb_data   <= 24'd0;
    end else begin
      if (mem_wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (load_mem_s) begin
        {fb_addr, fb_data} <= mem_r[rd_ptr_r];
        fb_we              <= 1'b1;
        rd_ptr_r           <= rd_ptr_r + PTR_W'(1);
      end else if (bypass_s) begin
        {fb_addr, fb_data} <= push_entry_s;
        fb_we              <= 1'b1;
      end else if (head_free_s) begin
        fb_we <= 1'b0;
      end
      mem_cnt_r <= mem_cnt_r + (PTR_W + 1)'(mem_wr_s) - (PTR_W + 1)'(load_mem_s);
    end
  end

endmodule

// File: tb/tb_spi_frame_loader.sv
// Scoreboard bench for spi_frame_loader: a behavioural model predicts every
// framebuffer write and register value; a monitor checks DUT writes.
module tb_spi_frame_loader;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4;
`ifdef SPI_LOADER_SWAP_EN
  localparam bit SWAP_ON = 1'b1;
`else
  localparam bit SWAP_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [31:0]       word_in = 32'd0;
  logic              word_first = 1'b0;
  logic              word_done = 1'b0;
  logic [ADDR_W:0]   fb_addr;
  logic [23:0]       fb_data;
  logic              fb_we;
  logic              fb_ready = 1'b0;
  logic              vsync = 1'b0;
  logic              front_buf;
  logic [7:0]        brightness;
  logic              err_overflow;
  logic              err_cmd;

  spi_frame_loader #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .word_in(word_in), .word_first(word_first),
    .word_done(word_done), .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we),
    .fb_ready(fb_ready), .vsync(vsync), .front_buf(front_buf),
    .brightness(brightness), .err_overflow(err_overflow), .err_cmd(err_cmd)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_seen = 0;

  // Expected framebuffer writes {buffer, address, rgb} in order.
  logic [ADDR_W+24:0] sb_q[$];

  // Behavioural model state.
  bit       m_payload;
  int       m_addr;
  int       m_count;
  bit [7:0] m_bright;
  bit       m_eovf, m_ecmd, m_front, m_pending;
  int       m_occ;

  task automatic expect_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_payload = 0; m_addr = 0; m_count = 0; m_bright = 8'd0;
    m_eovf = 0; m_ecmd = 0; m_front = 0; m_pending = 0; m_occ = 0;
    sb_q.delete();
  endtask

  // Apply the spec rules for one clock given the inputs presented to it.
  task automatic model_step(input logic [31:0] w, input bit f, input bit d,
                            input bit r, input bit v, input bit rn);
    bit pop, push, swap, hdr_swap, bufb;
    logic [ADDR_W-1:0] a;
    if (!rn) begin
      model_reset();
      return;
    end
    pop      = (m_occ > 0) && r;
    swap     = SWAP_ON && v && m_pending && (m_occ == 0);
    bufb     = SWAP_ON ? !m_front : 1'b0;
    push     = 0;
    hdr_swap = 0;
    if (d && m_payload && !f) begin
      a = ADDR_W'(m_addr);
      if (m_occ < DEPTH || pop) begin
        sb_q.push_back({bufb, a, w[23:0]});
        push = 1;
      end else begin
        m_eovf = 1;
      end
      m_addr  = (m_addr + 1) % (1 << ADDR_W);
      m_count = m_count - 1;
      if (m_count == 0) m_payload = 0;
    end else if (d) begin
      m_payload = 0;
      case (int'(w[31:28]))
        1: if (w[27:16] != 12'd0) begin
             m_payload = 1;
             m_addr    = int'(w[ADDR_W-1:0]);
             m_count   = int'(w[27:16]);
           end
        2: m_bright = w[7:0];
        3: if (SWAP_ON) hdr_swap = 1; else m_ecmd = 1;
        4: begin m_eovf = 0; m_ecmd = 0; end
        default: m_ecmd = 1;
      endcase
    end
    if (swap) m_front = !m_front;
    m_pending = (m_pending && !swap) || hdr_swap;
    m_occ = m_occ + int'(push) - int'(pop);
  endtask

  task automatic check_regs();
    expect_eq("brightness", 64'(brightness), 64'(m_bright));
    expect_eq("err_overflow", 64'(err_overflow), 64'(m_eovf));
    expect_eq("err_cmd", 64'(err_cmd), 64'(m_ecmd));
    expect_eq("front_buf", 64'(front_buf), 64'(m_front));
    expect_eq("fb_we_level", 64'(fb_we), 64'(m_occ > 0));
  endtask

  // One clock: check registers, drive inputs, advance model, wait for edge.
  task automatic step(input logic [31:0] w, input bit f, input bit d,
                      input bit r, input bit v, input bit rn);
    check_regs();
    word_in = w; word_first = f; word_done = d; fb_ready = r; vsync = v; resetn = rn;
    model_step(w, f, d, r, v, rn);
    @(posedge clk);
    #1;
  endtask

  task automatic hdr(input logic [31:0] w, input bit r);
    step(w, 1'b0, 1'b1, r, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) step(32'd0, 1'b0, 1'b0, r, 1'b0, 1'b1);
  endtask

  task automatic pix(input bit r);
    step($urandom, 1'b0, 1'b1, r, 1'b0, 1'b1);
  endtask

  function automatic logic [31:0] rand_header();
    logic [31:0] h;
    int sel;
    int op;
    sel = int'($urandom_range(0, 15));
    if (sel < 8) op = 1;
    else if (sel < 10) op = 2;
    else if (sel < 12) op = 3;
    else if (sel < 13) op = 4;
    else op = int'($urandom_range(5, 15));
    h = $urandom;
    h[31:28] = 4'(op);
    h[27:16] = 12'($urandom_range(0, 9));
    if ($urandom_range(0, 3) == 0) h[11:0] = 12'hFFC + 12'($urandom_range(0, 3));
    return h;
  endfunction

  // Monitor: score every transfer and check hold-stability under back-pressure.
  initial begin : monitor
    bit hold_we;
    logic [ADDR_W+24:0] hold_v;
    logic [ADDR_W+24:0] exp_v;
    hold_we = 0;
    hold_v  = '0;
    forever begin
      @(negedge clk);
      if (resetn && hold_we) begin
        expect_eq("hold_stable", {63'(fb_addr), fb_data, fb_we},
                  {63'(hold_v[ADDR_W+24:24]), hold_v[23:0], 1'b1});
      end
      hold_we = 0;
      if (resetn && fb_we && !fb_ready) begin
        hold_we = 1;
        hold_v  = {fb_addr, fb_data};
      end
      if (resetn && fb_we && fb_ready) begin
        wr_seen++;
        if (sb_q.size() == 0) begin
          expect_eq("unexpected_write", 64'({fb_addr, fb_data}), 64'd0);
        end else begin
          exp_v = sb_q.pop_front();
          expect_eq("fb_write", 64'({fb_addr, fb_data}), 64'(exp_v));
        end
      end
    end
  end

  initial begin : stim
    int w0;
    bit rdy_hi;
    bit r;
    model_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect_eq("reset_fb_addr", 64'(fb_addr), 64'd0);
    expect_eq("reset_fb_data", 64'(fb_data), 64'd0);
    idle(1, 1'b0);
    step(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // BRIGHT header.
    step(32'h2000_00A5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    expect_eq("bright_a5", 64'(brightness), 64'h00A5);
    idle(2, 1'b1);

    // WRITE of 3 pixels wrapping the address space.
    hdr(32'h1003_0FFE, 1'b1);
    for (int i = 0; i < 3; i++) pix(1'b1);
    idle(4, 1'b1);

    // Overflow: 8 pixels, one every 2 cycles, framebuffer stalled.
    hdr(32'h1008_0100, 1'b0);
    for (int i = 0; i < 8; i++) begin
      pix(1'b0);
      idle(1, 1'b0);
    end
    expect_eq("ovf_flag", 64'(err_overflow), 64'd1);
    expect_eq("ovf_queued", 64'(sb_q.size()), 64'd4);
    w0 = wr_seen;
    idle(8, 1'b1);
    expect_eq("ovf_writes", 64'(wr_seen - w0), 64'd4);
    hdr(32'h4000_0000, 1'b1);
    expect_eq("clr_ovf", 64'(err_overflow), 64'd0);

    // Abort by word_first carrying a BRIGHT header.
    hdr(32'h1005_0040, 1'b1);
    pix(1'b1);
    step(32'h2000_0010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    expect_eq("abort_bright", 64'(brightness), 64'h0010);
    hdr(32'h2000_0033, 1'b1);
    expect_eq("abort_idle", 64'(brightness), 64'h0033);
    idle(3, 1'b1);

    // SWAP sequencing (or unknown opcode in the single-buffer build).
    hdr(32'h3000_0000, 1'b1);
    if (SWAP_ON) begin
      hdr(32'h1002_0200, 1'b0);
      pix(1'b0);
      pix(1'b0);
      step(32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      expect_eq("swap_blocked", 64'(front_buf), 64'd0);
      idle(4, 1'b1);
      step(32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      expect_eq("swap_done", 64'(front_buf), 64'd1);
      hdr(32'h1001_0005, 1'b1);
      pix(1'b1);
      idle(3, 1'b1);
    end else begin
      expect_eq("swap_unknown", 64'(err_cmd), 64'd1);
      hdr(32'h4000_0000, 1'b1);
    end

    // Unknown opcode then a normal header.
    hdr(32'h7000_0000, 1'b1);
    expect_eq("op7_err", 64'(err_cmd), 64'd1);
    hdr(32'h2000_0042, 1'b1);
    expect_eq("op7_next", 64'(brightness), 64'h0042);
    hdr(32'h4000_0000, 1'b1);

    // Reset in the middle of a packet discards queued words.
    hdr(32'h1004_0300, 1'b0);
    pix(1'b0);
    pix(1'b0);
    step(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_eq("midrst_we", 64'(fb_we), 64'd0);
    expect_eq("midrst_bright", 64'(brightness), 64'd0);
    idle(3, 1'b1);

    // Randomized traffic.
    rdy_hi = 1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 49) == 0) rdy_hi = !rdy_hi;
      r = rdy_hi ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 2) == 0) begin
        if (!m_payload) begin
          step(rand_header(), 1'($urandom_range(0, 1)), 1'b1, r, 1'($urandom_range(0, 19) == 0), 1'b1);
        end else if ($urandom_range(0, 15) == 0) begin
          step(rand_header(), 1'b1, 1'b1, r, 1'($urandom_range(0, 19) == 0), 1'b1);
        end else begin
          step($urandom, 1'b0, 1'b1, r, 1'($urandom_range(0, 19) == 0), 1'b1);
        end
      end else begin
        step(32'd0, 1'b0, 1'b0, r, 1'($urandom_range(0, 19) == 0), 1'b1);
      end
    end

    // Drain within a bounded number of cycles.
    for (int i = 0; i < 50 && m_occ > 0; i++) idle(1, 1'b1);
    idle(2, 1'b1);
    expect_eq("drain_empty", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
